// File: rtl/uart_char_rx.sv
// UART 8N1 receiver that filters bytes to 7-bit ASCII and queues them for the parser.
// Latency: stop sample at edge T, FIFO write at T+1, char_valid high after edge T+2 (empty FIFO, hold=0).
// Backpressure: hold pauses FIFO output; a byte that arrives at a full FIFO with no pop is dropped and flagged.
module uart_char_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int DROP_CR      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic                          hold,
    input  logic                          clear_err,
    output logic [6:0]                    ascii_char,
    output logic                          char_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          framing_err,
    output logic                          nonascii_err,
    output logic                          overrun_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Synchronizer and receive state
    logic             rx_meta_q, rxs_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             stop_vld_q, stop_vld_d;
    logic             stop_ok_q, stop_ok_d;

    // FIFO and output state
    logic [6:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic [6:0]       ascii_q;
    logic             valid_q;
    logic             framing_q, nonascii_q, overrun_q;

    // Filter / FIFO control
    logic push_req, push, pop, full;
    logic fe_set, ne_set, oe_set;

    // Two-flop synchronizer; idles high so reset release never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    // Receive FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            stop_vld_q <= 1'b0;
            stop_ok_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            stop_vld_q <= stop_vld_d;
            stop_ok_q  <= stop_ok_d;
        end
    end

    // Receive FSM next state: mid-bit sampling, LSB first; leaves STOP on the sample edge
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        stop_vld_d = 1'b0;
        stop_ok_d  = stop_ok_q;
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d   = START;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rxs_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d      = '0;
                    stop_vld_d = 1'b1;
                    stop_ok_d  = rxs_q;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Character filter and FIFO push/pop decisions; shift_q is stable until the next frame's data bits
    always_comb begin
        full     = (level_q == LVL_FULL);
        pop      = (level_q != '0) && !hold;
        fe_set   = stop_vld_q && !stop_ok_q;
        ne_set   = stop_vld_q && stop_ok_q && shift_q[7];
        push_req = stop_vld_q && stop_ok_q && !shift_q[7] &&
                   !((DROP_CR != 0) && (shift_q == 8'h0D));
        push     = push_req && (!full || pop);
        oe_set   = push_req && full && !pop;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // FIFO storage; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= shift_q[6:0];
        end
    end

    // FIFO pointers, occupancy, output strobe and sticky error flags (set beats clear)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ascii_q    <= '0;
            valid_q    <= 1'b0;
            framing_q  <= 1'b0;
            nonascii_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            valid_q <= pop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                ascii_q  <= mem[rd_ptr_q];
            end
            framing_q  <= (framing_q  && !clear_err) || fe_set;
            nonascii_q <= (nonascii_q && !clear_err) || ne_set;
            overrun_q  <= (overrun_q  && !clear_err) || oe_set;
        end
    end

    assign ascii_char   = ascii_q;
    assign char_valid   = valid_q;
    assign fifo_level   = level_q;
    assign framing_err  = framing_q;
    assign nonascii_err = nonascii_q;
    assign overrun_err  = overrun_q;

endmodule

// File: tb/tb_uart_char_rx.sv
// Bench for uart_char_rx: drives UART frames on rxd and checks delivered characters and flags.
module tb_uart_char_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;

    logic       clk, rst, rxd, hold, clear_err;
    logic [6:0] ascii_char;
    logic       char_valid;
    logic [3:0] fifo_level;
    logic       framing_err, nonascii_err, overrun_err;

    uart_char_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DROP_CR(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .rxd          (rxd),
        .hold         (hold),
        .clear_err    (clear_err),
        .ascii_char   (ascii_char),
        .char_valid   (char_valid),
        .fifo_level   (fifo_level),
        .framing_err  (framing_err),
        .nonascii_err (nonascii_err),
        .overrun_err  (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic hold_seen = 1'b0;

    // Behavioural model: expected character stream and flag state
    logic [6:0] exp_q[$];
    int         strobe_cyc[$];
    logic       m_fe = 0, m_ne = 0, m_oe = 0;
    logic       m_hold = 0;
    int         m_lvl = 0;
    logic [6:0] m_last = 0;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        hold_seen <= hold;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Outcome of one received frame, decided purely from the byte value and stop bit
    task automatic model_rx(input logic [7:0] b, input logic stop);
        if (!stop)                       m_fe = 1'b1;
        else if (b[7])                   m_ne = 1'b1;
        else if (b == 8'h0D)             begin end
        else if (m_hold && m_lvl == DEPTH) m_oe = 1'b1;
        else begin
            exp_q.push_back(b[6:0]);
            m_last = b[6:0];
            if (m_hold) m_lvl++;
        end
    endtask

    // Every delivered strobe must match the head of the expected stream
    always @(negedge clk) begin
        if (rst && char_valid) begin
            strobe_cyc.push_back(cyc);
            check("strobe_while_hold", {31'd0, hold_seen}, 32'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_strobe: got char 0x%0h, expected no strobe", ascii_char);
            end else begin
                check("char", {25'd0, ascii_char}, {25'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame bits are driven 1 time unit after a rising edge and held CPB cycles each
    task automatic send_byte(input logic [7:0] b, input logic stop);
        model_rx(b, stop);
        rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(CPB);
        end
        rxd = stop;
        idle(CPB);
        rxd = 1'b1;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        idle(1);
        clear_err = 1'b0;
        m_fe = 0; m_ne = 0; m_oe = 0;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_framing"},  {31'd0, framing_err},  {31'd0, m_fe});
        check({tag, "_nonascii"}, {31'd0, nonascii_err}, {31'd0, m_ne});
        check({tag, "_overrun"},  {31'd0, overrun_err},  {31'd0, m_oe});
    endtask

    logic [7:0] hold_str [9] = '{8'h69, 8'h66, 8'h20, 8'h28, 8'h28, 8'h78, 8'h5F, 8'h76, 8'h3B};
    int t0;

    initial begin
        rst = 1'b1; rxd = 1'b1; hold = 1'b0; clear_err = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_ascii", {25'd0, ascii_char}, 32'd0);
        check("rst_valid", {31'd0, char_valid}, 32'd0);
        check("rst_level", {28'd0, fifo_level}, 32'd0);
        check_flags("rst");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(3);

        // Two back-to-back frames; first strobe 157 cycles after the start bit begins
        t0 = cyc;
        send_byte(8'h69, 1'b1);
        send_byte(8'h66, 1'b1);
        idle(6);
        check("b2b_count", strobe_cyc.size(), 32'd2);
        if (strobe_cyc.size() == 2) begin
            check("latency_first",  strobe_cyc[0] - t0, 32'd157);
            check("latency_second", strobe_cyc[1] - t0, 32'd317);
        end
        check("b2b_hold_last", {25'd0, ascii_char}, 32'h66);
        check_flags("b2b");

        // Framing error, clear, then normal byte
        send_byte(8'h41, 1'b0);
        idle(4);
        check("frame_flag_lit", {31'd0, framing_err}, 32'd1);
        check_flags("frame");
        pulse_clear();
        check_flags("frame_clr");
        send_byte(8'h42, 1'b1);
        idle(4);
        check("after_frame_char", {25'd0, ascii_char}, {25'd0, m_last});

        // Non-ASCII byte, then CR dropped and LF delivered
        send_byte(8'hC1, 1'b1);
        idle(4);
        check_flags("nonascii");
        send_byte(8'h0D, 1'b1);
        send_byte(8'h0A, 1'b1);
        idle(4);
        check("lf_char", {25'd0, ascii_char}, 32'h0A);
        pulse_clear();
        check_flags("nonascii_clr");

        // Hold: fill FIFO, overrun on ninth byte, then drain with consecutive strobes
        hold = 1'b1; m_hold = 1'b1;
        for (int i = 0; i < 9; i++) send_byte(hold_str[i], 1'b1);
        idle(4);
        check("hold_level", {28'd0, fifo_level}, m_lvl);
        check("hold_level_lit", {28'd0, fifo_level}, 32'd8);
        check_flags("hold");
        strobe_cyc.delete();
        hold = 1'b0; m_hold = 1'b0; m_lvl = 0;
        idle(15);
        check("drain_count", strobe_cyc.size(), 32'd8);
        if (strobe_cyc.size() == 8)
            check("drain_consecutive", strobe_cyc[7] - strobe_cyc[0], 32'd7);
        check("drain_level", {28'd0, fifo_level}, 32'd0);
        check("drain_last", {25'd0, ascii_char}, 32'h76);
        pulse_clear();

        // Short low glitch is rejected at the start-bit midpoint
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(30);
        check("glitch_level", {28'd0, fifo_level}, 32'd0);
        check_flags("glitch");
        send_byte(8'h3B, 1'b1);
        idle(4);
        check("semicolon", {25'd0, ascii_char}, 32'h3B);

        // Reset in DATA bit 3 after a framing error; everything clears at once
        send_byte(8'h41, 1'b0);
        idle(4);
        rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3; i++) begin
            rxd = (8'h65 >> i) & 1;
            idle(CPB);
        end
        rxd = 1'b0;
        idle(CPB / 2);
        rst = 1'b0;
        #2;
        m_fe = 0; m_ne = 0; m_oe = 0; m_last = 0;
        check("mid_rst_ascii", {25'd0, ascii_char}, 32'd0);
        check("mid_rst_valid", {31'd0, char_valid}, 32'd0);
        check("mid_rst_level", {28'd0, fifo_level}, 32'd0);
        check_flags("mid_rst");
        rxd = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(3);
        send_byte(8'h65, 1'b1);
        idle(4);
        check("post_rst_char", {25'd0, ascii_char}, 32'h65);
        check_flags("post_rst");

        check("stream_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
